// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: the decoded instruction record,
// the default queue depth and a pointer type sized from it.
package dispatch_queue_pkg;

  // Decoded instruction as handed from decode to issue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } inst_t;

  localparam int DQ_DEPTH = 8;
  localparam int DQ_PTR_W = $clog2(DQ_DEPTH);

  typedef logic [DQ_PTR_W-1:0] dq_ptr_t;

  // Number of set bits in a two-lane mask (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/dispatch_queue_mem.sv
// Entry storage for the dispatch queue: DEPTH x inst_t registers with two
// write ports and two asynchronous read ports. Addresses and enables come
// from the parent; the two write addresses are always distinct.
module dispatch_queue_mem
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = DQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [1:0]            we,
  input  logic [1:0][PTR_W-1:0] waddr,
  input  inst_t [1:0]           wdata,
  input  logic [1:0][PTR_W-1:0] raddr,
  output inst_t [1:0]           rdata
);

  // Storage is intentionally not reset; valid bits live in the parent.
  inst_t mem [DEPTH];

  // Write up to two entries per cycle.
  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr[0]] <= wdata[0];
    if (we[1]) mem[waddr[1]] <= wdata[1];
  end

  assign rdata[0] = mem[raddr[0]];
  assign rdata[1] = mem[raddr[1]];

endmodule

// File: rtl/dispatch_queue.sv
// Dual-issue dispatch queue between decode and issue. Holds up to DEPTH
// decoded instructions, accepts pairs from decode and retires 0..2 per
// cycle as reported by issue. A flush empties it in one cycle.
//
// Handshake: decode may offer instructions on f_valid_i (00/01/11) every
// cycle; they are taken only in a cycle where f_ready_o=1, and f_ready_o
// depends on registered state only (never on f_valid_i or is_i). On the
// issue side d_valid_o marks which of inst_o[0..1] hold live entries; issue
// answers with is_i (00/01/11, a subset of d_valid_o) and those entries are
// consumed at that clock edge. Pushed entries appear on inst_o one cycle
// later (no bypass).
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = DQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  inst_t [1:0] inst_i,
  input  logic  [1:0] f_valid_i,
  output logic        f_ready_o,
  output inst_t [1:0] inst_o,
  output logic  [1:0] d_valid_o,
  input  logic  [1:0] is_i
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head_q, tail_q;
  logic [COUNT_W-1:0] count_q;

  logic [1:0]            push_n, pop_n;
  logic [1:0]            we;
  logic [1:0][PTR_W-1:0] waddr, raddr;

  // Readiness only when a full pair fits, so decode never has to split.
  assign f_ready_o = (count_q <= COUNT_W'(DEPTH - 2));
  assign d_valid_o = {count_q >= COUNT_W'(2), count_q >= COUNT_W'(1)};

  // Push/pop amounts and storage port addressing for this cycle.
  always_comb begin
    push_n   = f_ready_o ? popcount2(f_valid_i) : 2'd0;
    pop_n    = popcount2(is_i);
    we       = f_ready_o ? f_valid_i : 2'b00;
    waddr[0] = tail_q;
    waddr[1] = tail_q + PTR_W'(1);
    raddr[0] = head_q;
    raddr[1] = head_q + PTR_W'(1);
  end

  // Pointer and occupancy update; flush takes priority over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop_n);
      tail_q  <= tail_q + PTR_W'(push_n);
      count_q <= count_q + COUNT_W'(push_n) - COUNT_W'(pop_n);
    end
  end

  dispatch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (inst_i),
    .raddr (raddr),
    .rdata (inst_o)
  );

  // Interface legality checks on the decode and issue sides.
  a_fvalid_shape : assert property (@(posedge clk) disable iff (rst)
    f_valid_i != 2'b10);
  a_is_shape : assert property (@(posedge clk) disable iff (rst)
    is_i != 2'b10);
  a_is_subset : assert property (@(posedge clk) disable iff (rst)
    (is_i & ~d_valid_o) == 2'b00);
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count_q <= COUNT_W'(DEPTH));

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: table of cycle vectors with expected flags,
// hand-written wrap and reset sequences, and a random phase. Issued data is
// checked against a reference FIFO (exp_q) fed on every accepted push.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush_i;
  inst_t [1:0] inst_i;
  logic  [1:0] f_valid_i;
  logic        f_ready_o;
  inst_t [1:0] inst_o;
  logic  [1:0] d_valid_o;
  logic  [1:0] is_i;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .inst_i    (inst_i),
    .f_valid_i (f_valid_i),
    .f_ready_o (f_ready_o),
    .inst_o    (inst_o),
    .d_valid_o (d_valid_o),
    .is_i      (is_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] fv;
    logic [1:0] is;
    logic       fl;
    logic [1:0] dv;
    logic       fr;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic inst_t rand_inst();
    inst_t r;
    r.pc  = $urandom;
    r.raw = $urandom;
    return r;
  endfunction

  // Compare the visible queue state with the reference model.
  task automatic check_state();
    int n;
    n = exp_q.size();
    check("d_valid_model", {62'd0, d_valid_o}, {62'd0, (n >= 2), (n >= 1)});
    check("f_ready_model", {63'd0, f_ready_o}, {63'd0, (n <= DEPTH - 2)});
    if (n >= 1) check("head0_data", inst_o[0], exp_q[0]);
    if (n >= 2) check("head1_data", inst_o[1], exp_q[1]);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input logic [1:0] fv, input logic [1:0] is, input logic fl);
    inst_t a, b;
    bit    accept;
    a = rand_inst();
    b = rand_inst();
    inst_i[0] = a;
    inst_i[1] = b;
    f_valid_i = fv;
    is_i      = is;
    flush_i   = fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      accept = (exp_q.size() <= DEPTH - 2);
      for (int k = 0; k < 2; k++) begin
        if (is[k]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_underflow: model empty at %0t", $time);
          end else begin
            check("issue_data", inst_o[k], exp_q.pop_front());
          end
        end
      end
      if (accept && fv[0]) exp_q.push_back(a);
      if (accept && fv[1]) exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    f_valid_i = 2'b00;
    is_i      = 2'b00;
    flush_i   = 1'b0;
    check_state();
  endtask

  function automatic logic [1:0] rand_mask(input int lim);
    int r;
    r = $urandom_range(0, lim);
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
  endfunction

  // ---------------- test ----------------
  initial begin
    rst       = 1'b1;
    flush_i   = 1'b0;
    f_valid_i = 2'b00;
    is_i      = 2'b00;
    inst_i    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_d_valid", {62'd0, d_valid_o}, 64'd0);
    check("reset_f_ready", {63'd0, f_ready_o}, 64'd1);

    // fv, is, fl, expected d_valid, expected f_ready (after the edge)
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1}); // 2: first pair visible
    vq.push_back('{2'b01, 2'b00, 1'b0, 2'b11, 1'b1}); // 3
    vq.push_back('{2'b11, 2'b01, 1'b0, 2'b11, 1'b1}); // 4: push+pop together
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1}); // 6
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b0}); // 8: full
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b0}); // 8: pair refused
    vq.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 1'b0}); // 7
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b0}); // 7: refused at DEPTH-1
    vq.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 1'b1}); // 6
    vq.push_back('{2'b11, 2'b11, 1'b0, 2'b11, 1'b1}); // 6
    vq.push_back('{2'b00, 2'b11, 1'b0, 2'b11, 1'b1}); // 4
    vq.push_back('{2'b00, 2'b11, 1'b0, 2'b11, 1'b1}); // 2
    vq.push_back('{2'b00, 2'b01, 1'b0, 2'b01, 1'b1}); // 1
    vq.push_back('{2'b00, 2'b01, 1'b0, 2'b00, 1'b1}); // 0
    vq.push_back('{2'b01, 2'b00, 1'b0, 2'b01, 1'b1}); // 1
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1}); // 3
    vq.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1}); // 5
    vq.push_back('{2'b11, 2'b11, 1'b1, 2'b00, 1'b1}); // flush wins -> 0

    foreach (vq[i]) begin
      step(vq[i].fv, vq[i].is, vq[i].fl);
      check($sformatf("vec%0d_d_valid", i), {62'd0, d_valid_o}, {62'd0, vq[i].dv});
      check($sformatf("vec%0d_f_ready", i), {63'd0, f_ready_o}, {63'd0, vq[i].fr});
    end

    // Wrap: leave head at DEPTH-1 with the second entry at index 0, written
    // by a pair that straddles the end of storage.
    repeat (3) step(2'b11, 2'b00, 1'b0);  // count 6, tail 6
    step(2'b01, 2'b00, 1'b0);             // count 7, tail 7
    repeat (3) step(2'b00, 2'b11, 1'b0);  // count 1, head 6
    step(2'b11, 2'b01, 1'b0);             // writes 7,0; head 7; count 2
    check("wrap_d_valid", {62'd0, d_valid_o}, 64'd3);
    repeat (2) step(2'b00, 2'b01, 1'b0);  // drain in order
    check("wrap_empty", {62'd0, d_valid_o}, 64'd0);

    // Random push/issue/flush against the reference FIFO, with an
    // asynchronous reset pulse in the middle.
    for (int c = 0; c < 10000; c++) begin
      logic [1:0] fv, is;
      int n;
      n  = exp_q.size();
      fv = rand_mask(2);
      is = (n >= 2) ? rand_mask(2) : (n == 1) ? rand_mask(1) : 2'b00;
      step(fv, is, ($urandom_range(0, 63) == 0));
      if (c == 5000) begin
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("async_rst_d_valid", {62'd0, d_valid_o}, 64'd0);
        check("async_rst_f_ready", {63'd0, f_ready_o}, 64'd1);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
